// File: rtl/alu_pkg.sv
// Shared ALU definitions used by ALU control and the execute stage.
// Holds the operation encoding, the default datapath width and a small
// helper that classifies shift operations.
package alu_pkg;

    // Default operand/result width for every ALU-related block.
    localparam int ALU_DATA_WIDTH = 32;

    // Shift amounts come from the low five bits of operand A.
    localparam int SHAMT_WIDTH = 5;

    // Operation codes driven by ALU control. Codes 1011-1111 are unused
    // and produce a zero result.
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_NOR = 4'b0101,
        ALU_SLT = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SRA = 4'b1001,
        ALU_LUI = 4'b1010
    } alu_op_e;

    // True for the three operations that shift operand B by A[4:0].
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Handshake bus of the execute-stage ALU: upstream operation/operand
// transfer, downstream result transfer and the pipeline flush.
// The master drives operations and consumes results; the slave is alu_exec.
interface alu_exec_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
);
    // Upstream operation channel
    logic                  i_valid;
    logic                  o_ready;
    logic [3:0]            i_operation;
    logic [DATA_WIDTH-1:0] i_data_a;
    logic [DATA_WIDTH-1:0] i_data_b;

    // Pipeline control
    logic                  i_flush;

    // Downstream result channel
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_result;
    logic                  o_zero;

    modport master (
        output i_valid,
        output i_operation,
        output i_data_a,
        output i_data_b,
        output i_flush,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_result,
        input  o_zero
    );

    modport slave (
        input  i_valid,
        input  i_operation,
        input  i_data_a,
        input  i_data_b,
        input  i_flush,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_result,
        output o_zero
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (operation, A, B) -> result.
// Shifts here use a single-cycle barrel shifter; the execute stage decides
// whether to use it or to shift serially.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [3:0]            operation_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH-1:0]  and_w;
    logic [DATA_WIDTH-1:0]  or_w;
    logic [DATA_WIDTH-1:0]  xor_w;
    logic [DATA_WIDTH-1:0]  nor_w;
    logic [DATA_WIDTH-1:0]  sum_w;
    logic [DATA_WIDTH-1:0]  diff_w;
    logic                   slt_w;
    logic [SHAMT_WIDTH-1:0] shamt_w;

    // Bitwise logic unit, one slice per bit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_logic_bit
            assign and_w[gi] = data_a_i[gi] & data_b_i[gi];
            assign or_w[gi]  = data_a_i[gi] | data_b_i[gi];
            assign xor_w[gi] = data_a_i[gi] ^ data_b_i[gi];
            assign nor_w[gi] = ~(data_a_i[gi] | data_b_i[gi]);
        end
    endgenerate

    // Adder/subtractor wrap modulo 2^DATA_WIDTH; carries are discarded.
    assign sum_w   = data_a_i + data_b_i;
    assign diff_w  = data_a_i - data_b_i;
    assign slt_w   = $signed(data_a_i) < $signed(data_b_i);
    assign shamt_w = data_a_i[SHAMT_WIDTH-1:0];

    // Result select; unused operation codes give zero.
    always_comb begin
        result_o = '0;
        case (operation_i)
            ALU_ADD: result_o = sum_w;
            ALU_SUB: result_o = diff_w;
            ALU_AND: result_o = and_w;
            ALU_OR:  result_o = or_w;
            ALU_XOR: result_o = xor_w;
            ALU_NOR: result_o = nor_w;
            ALU_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, slt_w};
            ALU_SLL: result_o = data_b_i << shamt_w;
            ALU_SRL: result_o = data_b_i >> shamt_w;
            ALU_SRA: result_o = DATA_WIDTH'($signed(data_b_i) >>> shamt_w);
            ALU_LUI: result_o = data_b_i << 16;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshake on both sides, a one-deep
// registered result and flush support.
// Build option: define ALU_EXEC_SERIAL_SHIFT_EN to execute SLL/SRL/SRA one
// bit per cycle in a SHIFT state (latency = amount + 1). Without it every
// operation, shifts included, completes with latency 1 via alu_core.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic       i_clk,
    input  logic       i_rst,
    alu_exec_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]             state_q,  state_d;
    logic [SHAMT_WIDTH-1:0] cnt_q,    cnt_d;
    logic                   valid_q,  valid_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   zero_q,   zero_d;
    logic [DATA_WIDTH-1:0]  shreg_q,  shreg_d;
    logic [3:0]             shop_q,   shop_d;

    logic [DATA_WIDTH-1:0]  core_result;
    logic [DATA_WIDTH-1:0]  shift_step;
    logic                   ready_w;
    logic                   accept_w;
    logic                   drain_w;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .operation_i (bus.i_operation),
        .data_a_i    (bus.i_data_a),
        .data_b_i    (bus.i_data_b),
        .result_o    (core_result)
    );

    // Accept only from IDLE when the output slot is free or emptying this
    // cycle; a flush or reset cycle never accepts.
    assign ready_w  = (state_q == ST_IDLE) && (!valid_q || bus.i_ready)
                      && !bus.i_flush && !i_rst;
    assign accept_w = bus.i_valid && ready_w;
    assign drain_w  = valid_q && bus.i_ready;

    assign bus.o_ready  = ready_w;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_zero   = zero_q;

    // One-bit step of the serial shifter for the captured shift operation.
    always_comb begin
        shift_step = shreg_q;
        case (shop_q)
            ALU_SLL: shift_step = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            ALU_SRL: shift_step = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            ALU_SRA: shift_step = {shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};
            default: shift_step = shreg_q;
        endcase
    end

    // Next-state logic for the FSM, shift counter and output register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        shreg_d  = shreg_q;
        shop_d   = shop_q;

        if (bus.i_flush) begin
            // Discard the held result and any shift in progress.
            valid_d = 1'b0;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_SHIFT) begin
            // The output slot is empty while shifting; the last step writes it.
            shreg_d = shift_step;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == {{(SHAMT_WIDTH-1){1'b0}}, 1'b1}) begin
                state_d  = ST_IDLE;
                valid_d  = 1'b1;
                result_d = shift_step;
                zero_d   = (shift_step == '0);
            end
        end else begin
            if (drain_w) begin
                valid_d = 1'b0;
            end
            if (accept_w) begin
`ifdef ALU_EXEC_SERIAL_SHIFT_EN
                if (is_shift_op(bus.i_operation) &&
                    (bus.i_data_a[SHAMT_WIDTH-1:0] != '0)) begin
                    // Nonzero shift: run it serially; the slot stays empty.
                    state_d = ST_SHIFT;
                    cnt_d   = bus.i_data_a[SHAMT_WIDTH-1:0];
                    shreg_d = bus.i_data_b;
                    shop_d  = bus.i_operation;
                end else begin
                    valid_d  = 1'b1;
                    result_d = core_result;
                    zero_d   = (core_result == '0);
                end
`else
                valid_d  = 1'b1;
                result_d = core_result;
                zero_d   = (core_result == '0);
`endif
            end
        end
    end

    // State registers with synchronous reset; reset abandons any shift.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            shreg_q  <= '0;
            shop_q   <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            shreg_q  <= shreg_d;
            shop_q   <= shop_d;
        end
    end

endmodule
